bpu_gshare_btb: RTL and testbench

- Parametrised multi-lane branch predictor in front of fetch. It combines a gshare PHT, indexed by PC XOR a speculative global history register, with a direct-mapped tagged BTB.
- The BTB learns targets from the predecoder and JIRL targets from ROB commit.
- History is updated speculatively per fetch group and repaired from ROB snapshots on mispredict.

---
 rtl/bpu_gshare_btb_if.sv | 51 +++++
 rtl/bpu_gshare_btb.sv | 157 +++++++++++++++
 tb/tb_bpu_gshare_btb.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_gshare_btb_if.sv
// Predictor bus bundle: fetch lookup, ROB commit update, predecoder BTB writes (+ RAS with BPU_RAS_EN).
// Latency: n/a (wires only); master = fetch/ROB/predecoder side, slave = predictor.
// Backpressure: none; every field is sampled each cycle without a handshake.
interface bpu_gshare_btb_if #(
    parameter int LANES   = 4,
    parameter int GHR_LEN = 8
);
    logic [LANES*32-1:0] pc_i;
    logic                fetch_valid_i;
    logic [LANES-1:0]    hit_o;
    logic [LANES-1:0]    predict_o;
    logic [LANES*32-1:0] target_o;
    logic [GHR_LEN-1:0]  ghr_o;
    logic                upd_valid_i;
    logic                upd_taken_i;
    logic [31:0]         upd_pc_i;
    logic [GHR_LEN-1:0]  upd_ghr_i;
    logic                upd_mispredict_i;
    logic                upd_is_jirl_i;
    logic [31:0]         upd_target_i;
    logic [LANES-1:0]    pd_we_i;
    logic [LANES*32-1:0] pd_pc_i;
    logic [LANES*32-1:0] pd_target_i;
`ifdef BPU_RAS_EN
    logic [LANES-1:0]    pd_is_ret_i;
    logic                ras_push_i;
    logic [31:0]         ras_push_addr_i;
    logic                ras_pop_i;
    logic [31:0]         ras_top_o;
`endif

    modport master (
`ifdef BPU_RAS_EN
        output pd_is_ret_i, ras_push_i, ras_push_addr_i, ras_pop_i,
        input  ras_top_o,
`endif
        output pc_i, fetch_valid_i, upd_valid_i, upd_taken_i, upd_pc_i, upd_ghr_i,
               upd_mispredict_i, upd_is_jirl_i, upd_target_i, pd_we_i, pd_pc_i, pd_target_i,
        input  hit_o, predict_o, target_o, ghr_o
    );

    modport slave (
`ifdef BPU_RAS_EN
        input  pd_is_ret_i, ras_push_i, ras_push_addr_i, ras_pop_i,
        output ras_top_o,
`endif
        input  pc_i, fetch_valid_i, upd_valid_i, upd_taken_i, upd_pc_i, upd_ghr_i,
               upd_mispredict_i, upd_is_jirl_i, upd_target_i, pd_we_i, pd_pc_i, pd_target_i,
        output hit_o, predict_o, target_o, ghr_o
    );
endinterface

// File: rtl/bpu_gshare_btb.sv
// Multi-lane gshare PHT + direct-mapped tagged BTB predictor with speculative GHR and ROB repair.
// Latency: lookup is combinational from registered state; writes become visible the next cycle.
// Backpressure: none; fetch_valid_i only gates GHR advance, updates are accepted every cycle.
// Ports: clk, rst (async, active-low) plus bus (slave modport): fetch lookup pc_i/hit_o/predict_o/
//   target_o/ghr_o, ROB commit upd_*, predecoder pd_*. Optional return stack under macro BPU_RAS_EN
//   adds pd_is_ret_i, ras_push_i, ras_push_addr_i, ras_pop_i, ras_top_o (RAS_DEPTH power of two).
module bpu_gshare_btb #(
    parameter int LANES     = 4,
    parameter int PHT_IDX   = 8,
    parameter int BTB_IDX   = 6,
    parameter int GHR_LEN   = 8,
    parameter int RAS_DEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    bpu_gshare_btb_if.slave bus
);
    localparam int TAGW  = 30 - BTB_IDX;
    localparam int PHT_N = 1 << PHT_IDX;
    localparam int BTB_N = 1 << BTB_IDX;

    logic [1:0]         pht     [PHT_N];
    logic [BTB_N-1:0]   btb_vld;
    logic [TAGW-1:0]    btb_tag [BTB_N];
    logic [31:0]        btb_tgt [BTB_N];
    logic [GHR_LEN-1:0] ghr;
    logic [LANES-1:0]    lane_hit;
    logic [LANES-1:0]    lane_pred;
    logic [LANES*32-1:0] lane_tgt;
    logic [PHT_IDX-1:0]  upd_idx;
    logic                recover;

    // Word-offset bits of every PC are irrelevant to indexing and tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pc_i, bus.pd_pc_i, bus.upd_pc_i};

`ifdef BPU_RAS_EN
    localparam int RP = $clog2(RAS_DEPTH);
    logic [BTB_N-1:0] btb_ret;
    logic [31:0]      ras_mem [RAS_DEPTH];
    logic [RP-1:0]    ras_ptr;     // next free slot; top of stack lives at ras_ptr-1
    logic [RP:0]      ras_cnt;
    logic [RP-1:0]    ras_top_idx;
    logic [31:0]      ras_top;

    assign ras_top_idx   = ras_ptr - RP'(1);
    assign ras_top       = (ras_cnt == '0) ? 32'h0 : ras_mem[ras_top_idx];
    assign bus.ras_top_o = ras_top;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int k = 0; k < RAS_DEPTH; k++) ras_mem[k] <= 32'h0;
        end else if (bus.upd_mispredict_i) begin
            ras_cnt <= '0;
        end else if (bus.ras_push_i && bus.ras_pop_i && ras_cnt != '0) begin
            ras_mem[ras_top_idx] <= bus.ras_push_addr_i;
        end else if (bus.ras_push_i) begin
            // Also covers push+pop on an empty stack: the pop has nothing to remove.
            // When full, the slot at ras_ptr holds the oldest entry, so it is overwritten.
            ras_mem[ras_ptr] <= bus.ras_push_addr_i;
            ras_ptr          <= ras_ptr + RP'(1);
            if (ras_cnt != (RP+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (RP+1)'(1);
        end else if (bus.ras_pop_i && ras_cnt != '0) begin
            ras_ptr <= ras_top_idx;
            ras_cnt <= ras_cnt - (RP+1)'(1);
        end
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
`endif

    // Lookup: every lane sees the same GHR; target is driven even on a miss.
    always_comb begin
        lane_hit  = '0;
        lane_pred = '0;
        lane_tgt  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_hit[i]  = btb_vld[bus.pc_i[32*i+2 +: BTB_IDX]] &&
                           (btb_tag[bus.pc_i[32*i+2 +: BTB_IDX]] == bus.pc_i[32*i+BTB_IDX+2 +: TAGW]);
            lane_pred[i] = pht[bus.pc_i[32*i+2 +: PHT_IDX] ^ PHT_IDX'(ghr)][1];
            lane_tgt[32*i +: 32] = btb_tgt[bus.pc_i[32*i+2 +: BTB_IDX]];
`ifdef BPU_RAS_EN
            if (lane_hit[i] && btb_ret[bus.pc_i[32*i+2 +: BTB_IDX]])
                lane_tgt[32*i +: 32] = ras_top;
`endif
        end
    end

    assign bus.hit_o     = lane_hit;
    assign bus.predict_o = lane_pred;
    assign bus.target_o  = lane_tgt;
    assign bus.ghr_o     = ghr;

    // Speculative history: one bit per fetch group, only when some lane is a known branch.
    assign recover = bus.upd_valid_i && bus.upd_mispredict_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (recover) begin
            ghr <= {bus.upd_ghr_i[GHR_LEN-2:0], bus.upd_taken_i};
        end else if (bus.fetch_valid_i && !bus.upd_mispredict_i) begin
            if (|(lane_hit & lane_pred)) ghr <= {ghr[GHR_LEN-2:0], 1'b1};
            else if (|lane_hit)          ghr <= {ghr[GHR_LEN-2:0], 1'b0};
        end
    end

    // Counter trained with the history the branch was fetched under, not the current GHR.
    assign upd_idx = bus.upd_pc_i[2 +: PHT_IDX] ^ PHT_IDX'(bus.upd_ghr_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PHT_N; k++) pht[k] <= 2'b01;
        end else if (bus.upd_valid_i) begin
            if (bus.upd_taken_i && pht[upd_idx] != 2'b11)
                pht[upd_idx] <= pht[upd_idx] + 2'd1;
            else if (!bus.upd_taken_i && pht[upd_idx] != 2'b00)
                pht[upd_idx] <= pht[upd_idx] - 2'd1;
        end
    end

    // BTB: later assignments win on a shared index, so lane order then ROB JIRL gives the priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_vld <= '0;
            for (int k = 0; k < BTB_N; k++) begin
                btb_tag[k] <= '0;
                btb_tgt[k] <= 32'h0;
            end
`ifdef BPU_RAS_EN
            btb_ret <= '0;
`endif
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.pd_we_i[i]) begin
                    btb_vld[bus.pd_pc_i[32*i+2 +: BTB_IDX]] <= 1'b1;
                    btb_tag[bus.pd_pc_i[32*i+2 +: BTB_IDX]] <= bus.pd_pc_i[32*i+BTB_IDX+2 +: TAGW];
                    btb_tgt[bus.pd_pc_i[32*i+2 +: BTB_IDX]] <= bus.pd_target_i[32*i +: 32];
`ifdef BPU_RAS_EN
                    btb_ret[bus.pd_pc_i[32*i+2 +: BTB_IDX]] <= bus.pd_is_ret_i[i];
`endif
                end
            end
            if (bus.upd_valid_i && bus.upd_is_jirl_i) begin
                btb_vld[bus.upd_pc_i[2 +: BTB_IDX]] <= 1'b1;
                btb_tag[bus.upd_pc_i[2 +: BTB_IDX]] <= bus.upd_pc_i[BTB_IDX+2 +: TAGW];
                btb_tgt[bus.upd_pc_i[2 +: BTB_IDX]] <= bus.upd_target_i;
`ifdef BPU_RAS_EN
                // A resolved JIRL target is concrete; it must not be redirected to the RAS.
                btb_ret[bus.upd_pc_i[2 +: BTB_IDX]] <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_bpu_gshare_btb.sv
// Bench for bpu_gshare_btb: directed steps then random traffic against a behavioural model.
// Latency: model state advances at each rising edge; outputs are sampled 1 time unit after negedge.
// Backpressure: none exercised; inputs are driven every cycle.
module tb_bpu_gshare_btb;
    localparam int LANES = 4, PHT_IDX = 8, BTB_IDX = 6, GHR_LEN = 8, RAS_DEPTH = 8;
    localparam int PHT_N = 1 << PHT_IDX;
    localparam int BTB_N = 1 << BTB_IDX;
    localparam int GHR_N = 1 << GHR_LEN;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bpu_gshare_btb_if #(.LANES(LANES), .GHR_LEN(GHR_LEN)) bus ();

    bpu_gshare_btb #(.LANES(LANES), .PHT_IDX(PHT_IDX), .BTB_IDX(BTB_IDX),
                     .GHR_LEN(GHR_LEN), .RAS_DEPTH(RAS_DEPTH))
        dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference model: plain arrays indexed by PC arithmetic, history as an integer.
    int          m_pht [PHT_N];
    bit          m_vld [BTB_N];
    logic [31:0] m_tag [BTB_N];
    logic [31:0] m_tgt [BTB_N];
    bit          m_ret [BTB_N];
    int          m_ghr;
    logic [31:0] m_ras [$];
    bit          m_any_ht, m_any_hit;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ras_top();
        return (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
    endfunction

    function automatic logic [31:0] rpc();
        return 32'h1C000000 | ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < PHT_N; k++) m_pht[k] = 1;
        for (int k = 0; k < BTB_N; k++) begin
            m_vld[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ret[k] = 0;
        end
        m_ghr = 0;
        m_ras.delete();
    endtask

    task automatic idle();
        bus.pc_i = '0; bus.fetch_valid_i = 0;
        bus.upd_valid_i = 0; bus.upd_taken_i = 0; bus.upd_pc_i = 0; bus.upd_ghr_i = 0;
        bus.upd_mispredict_i = 0; bus.upd_is_jirl_i = 0; bus.upd_target_i = 0;
        bus.pd_we_i = 0; bus.pd_pc_i = '0; bus.pd_target_i = '0;
`ifdef BPU_RAS_EN
        bus.pd_is_ret_i = 0; bus.ras_push_i = 0; bus.ras_push_addr_i = 0; bus.ras_pop_i = 0;
`endif
    endtask

    task automatic check_outputs();
        logic [LANES-1:0]    eh, ep;
        logic [LANES*32-1:0] et;
        logic [31:0]         pc;
        int                  bi, pi;
        for (int i = 0; i < LANES; i++) begin
            pc = bus.pc_i[32*i +: 32];
            bi = int'((pc >> 2) % BTB_N);
            pi = int'((pc >> 2) % PHT_N) ^ m_ghr;
            eh[i] = m_vld[bi] && (m_tag[bi] == (pc >> (BTB_IDX + 2)));
            ep[i] = (m_pht[pi] >= 2);
            et[32*i +: 32] = m_tgt[bi];
`ifdef BPU_RAS_EN
            if (eh[i] && m_ret[bi]) et[32*i +: 32] = ras_top();
`endif
        end
        m_any_ht  = |(eh & ep);
        m_any_hit = |eh;
        chk("hit", 128'(bus.hit_o), 128'(eh));
        chk("predict", 128'(bus.predict_o), 128'(ep));
        chk("target", 128'(bus.target_o), 128'(et));
        chk("ghr", 128'(bus.ghr_o), 128'(m_ghr));
`ifdef BPU_RAS_EN
        chk("ras_top", 128'(bus.ras_top_o), 128'(ras_top()));
`endif
    endtask

    task automatic model_clock();
        int pi, bi;
        if (bus.upd_valid_i && bus.upd_mispredict_i)
            m_ghr = (int'(bus.upd_ghr_i) * 2 + int'(bus.upd_taken_i)) % GHR_N;
        else if (bus.fetch_valid_i && !bus.upd_mispredict_i) begin
            if (m_any_ht)       m_ghr = (m_ghr * 2 + 1) % GHR_N;
            else if (m_any_hit) m_ghr = (m_ghr * 2) % GHR_N;
        end
        if (bus.upd_valid_i) begin
            pi = int'((bus.upd_pc_i >> 2) % PHT_N) ^ int'(bus.upd_ghr_i);
            if (bus.upd_taken_i) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
            else                 m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
        end
        for (int i = 0; i < LANES; i++) begin
            if (bus.pd_we_i[i]) begin
                bi = int'((bus.pd_pc_i[32*i +: 32] >> 2) % BTB_N);
                m_vld[bi] = 1;
                m_tag[bi] = bus.pd_pc_i[32*i +: 32] >> (BTB_IDX + 2);
                m_tgt[bi] = bus.pd_target_i[32*i +: 32];
`ifdef BPU_RAS_EN
                m_ret[bi] = bus.pd_is_ret_i[i];
`endif
            end
        end
        if (bus.upd_valid_i && bus.upd_is_jirl_i) begin
            bi = int'((bus.upd_pc_i >> 2) % BTB_N);
            m_vld[bi] = 1;
            m_tag[bi] = bus.upd_pc_i >> (BTB_IDX + 2);
            m_tgt[bi] = bus.upd_target_i;
            m_ret[bi] = 0;
        end
`ifdef BPU_RAS_EN
        if (bus.upd_mispredict_i) m_ras.delete();
        else if (bus.ras_push_i && bus.ras_pop_i && m_ras.size() != 0)
            m_ras[m_ras.size()-1] = bus.ras_push_addr_i;
        else if (bus.ras_push_i) begin
            m_ras.push_back(bus.ras_push_addr_i);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end else if (bus.ras_pop_i && m_ras.size() != 0) void'(m_ras.pop_back());
`endif
    endtask

    task automatic settle();
        #1;
        check_outputs();
    endtask

    task automatic advance();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_lanes(input logic [31:0] l0, input logic [31:0] rest);
        bus.pc_i = {rest, rest, rest, l0};
    endtask

    initial begin
        idle();
        model_reset();
        // Reset state
        set_lanes(32'h1C000000, 32'h1C000000);
        settle();
        chk("rst_hit", 128'(bus.hit_o), 128'(0));
        chk("rst_pred", 128'(bus.predict_o), 128'(0));
        chk("rst_ghr", 128'(bus.ghr_o), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Predecoder write: not visible in the same cycle, visible the next
        idle();
        set_lanes(32'h1C000010, 32'h1C001010);
        bus.pd_we_i = 4'b0001; bus.pd_pc_i[31:0] = 32'h1C000010; bus.pd_target_i[31:0] = 32'h1C000100;
        settle();
        chk("btb_same_cycle", 128'(bus.hit_o[0]), 128'(0));
        advance();
        idle();
        set_lanes(32'h1C000010, 32'h1C001010);
        settle();
        chk("btb_next_cycle", 128'(bus.hit_o), 128'(4'b0001));
        chk("btb_target", 128'(bus.target_o[31:0]), 128'(32'h1C000100));
        advance();

        // Same index from pd lanes 1 and 3 plus a ROB JIRL
        idle();
        bus.pd_we_i = 4'b1010;
        bus.pd_pc_i[63:32] = 32'h1C000110;  bus.pd_target_i[63:32] = 32'h1C000200;
        bus.pd_pc_i[127:96] = 32'h1C000210; bus.pd_target_i[127:96] = 32'h1C000300;
        bus.upd_valid_i = 1; bus.upd_is_jirl_i = 1; bus.upd_taken_i = 1;
        bus.upd_pc_i = 32'h1C000310; bus.upd_target_i = 32'h1C000800;
        settle();
        advance();
        idle();
        set_lanes(32'h1C000310, 32'h1C000210);
        settle();
        chk("jirl_wins_target", 128'(bus.target_o[31:0]), 128'(32'h1C000800));
        chk("jirl_wins_hit", 128'(bus.hit_o), 128'(4'b0001));
        advance();

        // PHT saturating counter at pc 0x1C000020, history 0
        for (int n = 0; n < 5; n++) begin
            idle();
            set_lanes(32'h1C000020, 32'h1C000020);
            bus.upd_valid_i = 1; bus.upd_pc_i = 32'h1C000020; bus.upd_taken_i = (n < 2);
            settle();
            advance();
            if (n == 1) begin
                idle(); set_lanes(32'h1C000020, 32'h1C000020); settle();
                chk("pht_taken_sat", 128'(bus.predict_o[0]), 128'(1));
            end
        end
        idle(); set_lanes(32'h1C000020, 32'h1C000020); settle();
        chk("pht_nottaken_sat", 128'(bus.predict_o[0]), 128'(0));
        advance();

        // Train a strongly-taken branch at 0x1C000040
        for (int n = 0; n < 2; n++) begin
            idle();
            bus.pd_we_i = 4'b0001; bus.pd_pc_i[31:0] = 32'h1C000040; bus.pd_target_i[31:0] = 32'h1C000444;
            bus.upd_valid_i = 1; bus.upd_pc_i = 32'h1C000040; bus.upd_taken_i = 1;
            settle();
            advance();
        end
        // GHR: hit+taken, hit+not-taken, no hit, then recovery beats a concurrent fetch
        idle(); set_lanes(32'h1C000040, 32'h1C00F000); bus.fetch_valid_i = 1; settle(); advance();
        idle(); set_lanes(32'h1C000310, 32'h1C00F000); bus.fetch_valid_i = 1; settle();
        chk("ghr_taken", 128'(bus.ghr_o), 128'(8'h01));
        advance();
        idle(); set_lanes(32'h1C00F000, 32'h1C00F000); bus.fetch_valid_i = 1; settle();
        chk("ghr_not_taken", 128'(bus.ghr_o), 128'(8'h02));
        advance();
        idle(); set_lanes(32'h1C000040, 32'h1C00F000); bus.fetch_valid_i = 1;
        bus.upd_valid_i = 1; bus.upd_mispredict_i = 1; bus.upd_ghr_i = 8'h55; bus.upd_taken_i = 1;
        bus.upd_pc_i = 32'h1C000040;
        settle();
        chk("ghr_no_hit", 128'(bus.ghr_o), 128'(8'h02));
        advance();
        idle(); set_lanes(32'h1C00F000, 32'h1C00F000); settle();
        chk("ghr_recover", 128'(bus.ghr_o), 128'(8'hAB));
        advance();

`ifdef BPU_RAS_EN
        // RAS: overflow, drain, underflow, flush on mispredict
        for (int k = 1; k <= 9; k++) begin
            idle(); bus.ras_push_i = 1; bus.ras_push_addr_i = 32'h1C000000 + k * 32'h100;
            settle(); advance();
        end
        for (int k = 9; k >= 2; k--) begin
            idle(); bus.ras_pop_i = 1; settle();
            chk("ras_pop_order", 128'(bus.ras_top_o), 128'(32'h1C000000 + k * 32'h100));
            advance();
        end
        idle(); bus.ras_pop_i = 1; settle();
        chk("ras_empty", 128'(bus.ras_top_o), 128'(0));
        advance();
        for (int k = 1; k <= 3; k++) begin
            idle(); bus.ras_push_i = 1; bus.ras_push_addr_i = 32'h1C00A000 + k * 32'h4;
            settle(); advance();
        end
        idle(); bus.upd_mispredict_i = 1; bus.ras_push_i = 1; bus.ras_push_addr_i = 32'h1C00BEEC;
        settle();
        chk("ras_before_flush", 128'(bus.ras_top_o), 128'(32'h1C00A00C));
        advance();
        idle(); settle();
        chk("ras_flushed", 128'(bus.ras_top_o), 128'(0));
        advance();
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            for (int i = 0; i < LANES; i++) begin
                bus.pc_i[32*i +: 32] = rpc();
                bus.pd_pc_i[32*i +: 32] = rpc();
                bus.pd_target_i[32*i +: 32] = $urandom() & 32'hFFFF_FFFC;
            end
            bus.fetch_valid_i = 1'($urandom_range(0, 1));
            bus.pd_we_i = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b0;
            bus.upd_valid_i = 1'($urandom_range(0, 1));
            bus.upd_taken_i = 1'($urandom_range(0, 1));
            bus.upd_pc_i = rpc();
            bus.upd_ghr_i = 8'($urandom());
            bus.upd_mispredict_i = ($urandom_range(0, 9) == 0);
            bus.upd_is_jirl_i = ($urandom_range(0, 3) == 0);
            bus.upd_target_i = $urandom() & 32'hFFFF_FFFC;
`ifdef BPU_RAS_EN
            bus.pd_is_ret_i = 4'($urandom());
            bus.ras_push_i = 1'($urandom_range(0, 1));
            bus.ras_pop_i = 1'($urandom_range(0, 1));
            bus.ras_push_addr_i = $urandom() & 32'hFFFF_FFFC;
`endif
            settle();
            advance();
        end

        // Reset arriving mid-update discards the pending writes
        idle();
        bus.upd_valid_i = 1; bus.upd_taken_i = 1; bus.upd_is_jirl_i = 1; bus.upd_mispredict_i = 1;
        bus.upd_pc_i = 32'h1C000310; bus.upd_target_i = 32'h1C000900; bus.upd_ghr_i = 8'hFF;
        bus.pd_we_i = 4'b1111; bus.pd_pc_i = {4{32'h1C000310}}; bus.pd_target_i = {4{32'h1C000A00}};
        set_lanes(32'h1C000310, 32'h1C000310);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_mid_ghr", 128'(bus.ghr_o), 128'(0));
        @(posedge clk);
        @(negedge clk);
        idle();
        set_lanes(32'h1C000310, 32'h1C000310);
        rst = 1'b1;
        settle();
        chk("rst_mid_discard", 128'(bus.hit_o), 128'(0));
        advance();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
